// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : AHB encodings and the SRAM responder state type.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_slv_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_sram_array.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_array
// Description : Word array with synchronous write and combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_array
    import ahb_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_widx,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_ridx,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB SRAM responder with programmable wait states and a
//               two-cycle ERROR response for illegal or read-only accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 1,
    parameter int          RO_WORDS    = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int          c_idx_w     = $clog2(MEM_WORDS);
    localparam logic [32:0] c_span      = 33'(4 * MEM_WORDS);
    localparam logic [32:0] c_ro_span   = 33'(4 * RO_WORDS);
    localparam logic [3:0]  c_wait_init = 4'(WAIT_STATES - 1);

    ahb_slv_state_t     r_state;
    logic [3:0]         r_cnt;
    logic               r_sel;
    logic [1:0]         r_trans;
    logic               r_write;
    logic [2:0]         r_size;
    logic [31:2]        r_addr;
    logic               r_err;

    logic [32:0]        w_off;
    logic               w_act;
    logic               w_err;
    logic [c_idx_w-1:0] w_idx;
    logic [29:0]        w_dp_off;
    logic [c_idx_w-1:0] w_dp_idx;
    logic               w_dp_ok;
    logic               w_capture;
    logic               w_we;
    logic [c_idx_w-1:0] w_rd_idx;
    logic [31:0]        w_rd_data;
    logic [31:0]        w_fwd_data;
    logic               w_unused;

    // Address-phase decode; a borrow out of the subtraction means below base.
    assign w_off = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign w_act = HSEL && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign w_err = w_off[32] || (w_off >= c_span) || (HSIZE != HSIZE_WORD) ||
                   (HADDR[1:0] != 2'b00) || (HWRITE && (w_off < c_ro_span));
    assign w_idx = w_off[c_idx_w+1:2];

    // Data-phase view of the captured transfer.
    assign w_dp_off = r_addr - BASE_ADDR[31:2];
    assign w_dp_idx = w_dp_off[c_idx_w-1:0];
    assign w_dp_ok  = r_sel && r_trans[1] && !r_err && (r_size == HSIZE_WORD);

    assign w_capture = HREADY && HREADYOUT;
    assign w_we      = w_capture && (r_state == ST_IDLE) && w_dp_ok && r_write;
    assign w_rd_idx  = (r_state == ST_WAIT) ? w_dp_idx : w_idx;

    // Zero-wait read straight after a write to the same word sees the new data.
    assign w_fwd_data = (w_we && (w_dp_idx == w_idx)) ? HWDATA : w_rd_data;

    assign w_unused = &{1'b0, HBURST, r_trans[0], w_off[31:c_idx_w+2], w_off[1:0],
                        w_dp_off[29:c_idx_w]};

    ahb_sram_array #(
        .DEPTH (MEM_WORDS),
        .WIDTH (32)
    ) u_array (
        .clk     (HCLK),
        .i_we    (w_we),
        .i_widx  (w_dp_idx),
        .i_wdata (HWDATA),
        .i_ridx  (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_sel     <= 1'b0;
            r_trans   <= HTRANS_IDLE;
            r_write   <= 1'b0;
            r_size    <= 3'b000;
            r_addr    <= 30'd0;
            r_err     <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= 32'd0;
        end else begin
            if (w_capture) begin
                r_sel   <= HSEL;
                r_trans <= HTRANS;
                r_write <= HWRITE;
                r_size  <= HSIZE;
                r_addr  <= HADDR[31:2];
                r_err   <= w_err;
            end
            case (r_state)
                ST_IDLE, ST_ERR2: begin
                    r_state   <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                    if (w_capture && w_act) begin
                        if (w_err) begin
                            r_state   <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            r_state   <= ST_WAIT;
                            r_cnt     <= c_wait_init;
                            HREADYOUT <= 1'b0;
                        end else if (!HWRITE) begin
                            HRDATA <= w_fwd_data;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        if (!r_write) begin
                            HRDATA <= w_rd_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state   <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_sram_slave
// Description : Scoreboard bench for two responders (0 and 2 wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic [1:0]  hresp     [2];
    logic [31:0] hrdata    [2];

    ahb_sram_slave #(.BASE_ADDR(32'h0), .MEM_WORDS(256), .WAIT_STATES(0), .RO_WORDS(16)) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
        .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

    ahb_sram_slave #(.BASE_ADDR(32'h0), .MEM_WORDS(256), .WAIT_STATES(2), .RO_WORDS(16)) u_dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
        .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

    typedef struct {
        int          inst;
        bit          err;
        int          stalls;
        bit          chk_eq;
        bit          chk_ne;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] mdl   [2][256];
    bit          known [2][256];

    function automatic int ws(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    endtask

    // Monitor: one per responder, retires the oldest expectation on each completing cycle.
    for (genvar k = 0; k < 2; k++) begin : g_mon
        int          stalls = 0;
        logic [1:0]  p_resp;
        logic [31:0] p_data;
        always @(negedge HCLK) begin
            exp_t e;
            if (HRESET) begin
                stalls = 0;
            end else if (sb.size() > 0 && sb[0].inst == k) begin
                if (!hreadyout[k]) begin
                    if (stalls == 0 && sb[0].err)
                        chk(hresp[k] == HRESP_ERROR, "err1_resp", 32'(hresp[k]), 32'(HRESP_ERROR));
                    if (stalls > 0) begin
                        chk(hresp[k] == p_resp, "stall_resp_stable", 32'(hresp[k]), 32'(p_resp));
                        chk(hrdata[k] == p_data, "stall_rdata_stable", hrdata[k], p_data);
                    end
                    p_resp = hresp[k];
                    p_data = hrdata[k];
                    stalls++;
                    if (stalls > 40) begin
                        chk(1'b0, "stall_bound", 32'(stalls), 32'd40);
                        void'(sb.pop_front());
                        stalls = 0;
                    end
                end else begin
                    e = sb.pop_front();
                    chk(stalls == e.stalls, "stall_cycles", 32'(stalls), 32'(e.stalls));
                    chk(hresp[k] == (e.err ? HRESP_ERROR : HRESP_OKAY), "resp",
                        32'(hresp[k]), 32'(e.err ? HRESP_ERROR : HRESP_OKAY));
                    if (e.chk_eq) chk(hrdata[k] == e.data, "rdata", hrdata[k], e.data);
                    if (e.chk_ne) chk(hrdata[k] != e.data, "ro_unchanged_not", hrdata[k], e.data);
                    stalls = 0;
                end
            end
        end
    end

    // Drive one address phase, wait for it to be accepted, then predict its response.
    task automatic xfer(input int k, input bit sel, input logic [1:0] tr, input bit wr,
                        input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd, input bit ne);
        exp_t   e;
        int     guard;
        bit     act, err, inr;
        longint off;
        int     idx;
        hsel[k] = sel; htrans[k] = tr; hwrite[k] = wr; haddr[k] = a; hsize[k] = sz;
        guard = 0;
        @(negedge HCLK);
        while (!hreadyout[k] && guard < 50) begin
            @(negedge HCLK);
            guard++;
        end
        if (guard >= 50) chk(1'b0, "capture_timeout", 32'(guard), 32'd50);
        @(posedge HCLK);
        #1;
        off = longint'(a);
        act = sel && (tr == HTRANS_NONSEQ || tr == HTRANS_SEQ);
        inr = (off >= 0) && (off < 1024);
        err = act && (!inr || sz != 3'b010 || (a % 4) != 0 || (wr && off < 64));
        e.inst = k; e.err = err; e.chk_eq = 0; e.chk_ne = ne; e.data = wd;
        e.stalls = !act ? 0 : (err ? 1 : ws(k));
        if (act && !err) begin
            idx = int'(off / 4);
            if (wr) begin
                mdl[k][idx] = wd;
                known[k][idx] = 1'b1;
            end else if (known[k][idx]) begin
                e.chk_eq = 1'b1;
                e.data = mdl[k][idx];
            end
        end
        sb.push_back(e);
        if (wr) hwdata[k] = wd;
        hsel[k] = 1'b0; htrans[k] = HTRANS_IDLE; hwrite[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic directed(input int k);
        logic [31:0] d;
        logic [31:0] w [4];
        xfer(k, 1, HTRANS_NONSEQ, 1, (k == 0) ? 32'h40 : 32'h80, HSIZE_WORD, 32'hDEADBEEF, 0);
        xfer(k, 1, HTRANS_NONSEQ, 0, (k == 0) ? 32'h40 : 32'h80, HSIZE_WORD, 32'h0, 0);
        xfer(k, 1, HTRANS_NONSEQ, 0, 32'h0000_0400, HSIZE_WORD, 32'h0, 0);
        xfer(k, 1, HTRANS_NONSEQ, 0, (k == 0) ? 32'h40 : 32'h80, HSIZE_WORD, 32'h0, 0);
        d = $urandom | 32'h8000_0000;
        xfer(k, 1, HTRANS_NONSEQ, 1, 32'h10, HSIZE_WORD, d, 0);
        xfer(k, 1, HTRANS_NONSEQ, 0, 32'h10, HSIZE_WORD, d, 1);
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        hburst[k] = HBURST_INCR4;
        xfer(k, 1, HTRANS_NONSEQ, 1, 32'h100, HSIZE_WORD, w[0], 0);
        xfer(k, 1, HTRANS_SEQ,    1, 32'h104, HSIZE_WORD, w[1], 0);
        xfer(k, 1, HTRANS_BUSY,   1, 32'h108, HSIZE_WORD, w[1], 0);
        xfer(k, 1, HTRANS_SEQ,    1, 32'h108, HSIZE_WORD, w[2], 0);
        xfer(k, 1, HTRANS_SEQ,    1, 32'h10C, HSIZE_WORD, w[3], 0);
        for (int i = 0; i < 4; i++)
            xfer(k, 1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 0, 32'h100 + 32'(4 * i), HSIZE_WORD, 32'h0, 0);
        hburst[k] = HBURST_SINGLE;
    endtask

    task automatic random_traffic(input int k, input int n);
        int          c;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;
        bit          sel, wr;
        for (int i = 0; i < n; i++) begin
            c = int'($urandom_range(0, 9));
            sel = 1; sz = HSIZE_WORD; wr = $urandom_range(0, 1) == 1;
            tr = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
            a = 32'(4 * $urandom_range(16, 31));
            case (c)
                5: a = 32'(4 * $urandom_range(0, 15));
                6: a = ($urandom_range(0, 1) == 1) ? 32'h400 + 32'(4 * $urandom_range(0, 500))
                                                    : ($urandom | 32'h8000_0000);
                7: a = a + 32'($urandom_range(1, 3));
                8: sz = ($urandom_range(0, 1) == 1) ? 3'b000 : 3'b011;
                9: begin
                    sel = $urandom_range(0, 1) == 1;
                    tr = sel ? (($urandom_range(0, 1) == 1) ? HTRANS_BUSY : HTRANS_IDLE) : HTRANS_NONSEQ;
                end
                default: ;
            endcase
            xfer(k, sel, tr, wr, a, sz, $urandom, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v, wv;
        for (int k = 0; k < 2; k++) begin
            hsel[k] = 0; haddr[k] = 0; htrans[k] = HTRANS_IDLE; hwrite[k] = 0;
            hsize[k] = HSIZE_WORD; hburst[k] = HBURST_SINGLE; hwdata[k] = 0;
            for (int j = 0; j < 256; j++) known[k][j] = 1'b0;
        end
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(hreadyout[k] == 1'b1, "reset_hreadyout", 32'(hreadyout[k]), 32'd1);
            chk(hresp[k] == HRESP_OKAY, "reset_hresp", 32'(hresp[k]), 32'(HRESP_OKAY));
            chk(hrdata[k] == 32'd0, "reset_hrdata", hrdata[k], 32'd0);
        end
        @(negedge HCLK);
        HRESET = 1'b0;
        idle(1);

        directed(0);
        random_traffic(0, 80);
        idle(4);
        directed(1);
        random_traffic(1, 80);
        idle(4);

        // Reset while a write to 0x200 is stalled must leave the old word intact.
        v = $urandom;
        wv = ~v;
        xfer(1, 1, HTRANS_NONSEQ, 1, 32'h200, HSIZE_WORD, v, 0);
        xfer(1, 1, HTRANS_NONSEQ, 0, 32'h200, HSIZE_WORD, 32'h0, 0);
        idle(6);
        chk(sb.size() == 0, "pre_abort_drained", 32'(sb.size()), 32'd0);
        hsel[1] = 1; htrans[1] = HTRANS_NONSEQ; hwrite[1] = 1; haddr[1] = 32'h200; hsize[1] = HSIZE_WORD;
        @(posedge HCLK);
        #1;
        hwdata[1] = wv;
        hsel[1] = 0; htrans[1] = HTRANS_IDLE; hwrite[1] = 0;
        chk(hreadyout[1] == 1'b0, "abort_in_wait", 32'(hreadyout[1]), 32'd0);
        #3;
        HRESET = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(hreadyout[k] == 1'b1, "abort_hreadyout", 32'(hreadyout[k]), 32'd1);
            chk(hresp[k] == HRESP_OKAY, "abort_hresp", 32'(hresp[k]), 32'(HRESP_OKAY));
            chk(hrdata[k] == 32'd0, "abort_hrdata", hrdata[k], 32'd0);
        end
        @(negedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        idle(1);
        xfer(1, 1, HTRANS_NONSEQ, 0, 32'h200, HSIZE_WORD, 32'h0, 0);
        idle(8);
        chk(sb.size() == 0, "sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
